// File: rtl/if_id_stage_pkg.sv
// Shared core constants for the IF/ID stage: bus widths, boot PC, NOP encoding
// and reset polarity.
package if_id_stage_pkg;

    localparam int          InstAddrBus = 32;
    localparam int          InstBus     = 32;
    localparam logic [31:0] InitialPc   = 32'hBFC0_0000;
    localparam logic [31:0] NopInst     = 32'h0000_0000;
    localparam logic        RstEnable   = 1'b1;

endpackage

// File: rtl/if_id_buf.sv
// Circular {pc, inst} storage for the IF/ID stage.
// Holds the pointers, occupancy count and data array; flush empties it.
module if_id_buf
    import if_id_stage_pkg::*;
#(
    parameter int ADDR_W = InstAddrBus,
    parameter int INST_W = InstBus,
    parameter int DEPTH  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            wr_pc,
    input  logic [INST_W-1:0]            wr_inst,
    output logic [ADDR_W-1:0]            rd_pc,
    output logic [INST_W-1:0]            rd_inst,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] pc_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_d [DEPTH];
    logic [INST_W-1:0] inst_mem_q [DEPTH];
    logic [INST_W-1:0] inst_mem_d [DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy update; flush realigns read to write pointer.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Slot write; held entries are never touched.
    always_comb begin
        pc_mem_d   = pc_mem_q;
        inst_mem_d = inst_mem_q;
        if (push && !flush) begin
            pc_mem_d[wr_ptr_q]   = wr_pc;
            inst_mem_d[wr_ptr_q] = wr_inst;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data array registers; contents only matter while counted as valid.
    always_ff @(posedge clk) begin
        pc_mem_q   <= pc_mem_d;
        inst_mem_q <= inst_mem_d;
    end

    assign rd_pc   = pc_mem_q[rd_ptr_q];
    assign rd_inst = inst_mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/if_id_stage.sv
// Elastic IF/ID stage: DEPTH-entry {pc, inst} buffer with valid/ready and flush.
// Optional IF_ID_PERF_EN adds stall and bubble cycle counters.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int                ADDR_W  = InstAddrBus,
    parameter int                INST_W  = InstBus,
    parameter int                DEPTH   = 2,
    parameter logic [ADDR_W-1:0] INIT_PC = ADDR_W'(InitialPc)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_pc,
    input  logic [INST_W-1:0] if_inst,
    output logic              if_ready,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst,
    input  logic              id_ready,
    input  logic              flush
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] head_pc;
    logic [INST_W-1:0] head_inst;
    logic              push;
    logic              pop;

    assign if_ready = (count < FULL);
    assign id_valid = (count != '0);
    assign push     = if_valid && if_ready;
    assign pop      = id_valid && id_ready;

    if_id_buf #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wr_pc   (if_pc),
        .wr_inst (if_inst),
        .rd_pc   (head_pc),
        .rd_inst (head_inst),
        .count   (count)
    );

    // Empty stage presents the boot PC and a NOP to decode.
    always_comb begin
        id_pc   = INIT_PC;
        id_inst = INST_W'(NopInst);
        if (id_valid) begin
            id_pc   = head_pc;
            id_inst = head_inst;
        end
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_q, stall_d;
    logic [31:0] bubble_q, bubble_d;

    // Stall counts held heads; bubble counts empty cycles.
    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        if (id_valid && !id_ready) stall_d = stall_q + 32'd1;
        if (!id_valid)             bubble_d = bubble_q + 32'd1;
    end

    // Perf counter registers, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign perf_stall_cnt  = stall_q;
    assign perf_bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed checks for if_id_stage: reset, streaming, stall, flush, wrap, perf.
// DEPTH=2 and DEPTH=3 instances run side by side.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready, id_valid, id_ready, flush;
    logic [31:0] if_pc, if_inst, id_pc, id_inst;
    logic        if_valid3, if_ready3, id_valid3, id_ready3, flush3;
    logic [31:0] if_pc3, if_inst3, id_pc3, id_inst3;
`ifdef IF_ID_PERF_EN
    logic [31:0] stall_cnt, bubble_cnt, stall_cnt3, bubble_cnt3;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    if_id_stage #(.DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_ready (if_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_inst  (id_inst),
        .id_ready (id_ready),
        .flush    (flush)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cnt  (stall_cnt),
        .perf_bubble_cnt (bubble_cnt)
`endif
    );

    if_id_stage #(.DEPTH(3)) dut3 (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid3),
        .if_pc    (if_pc3),
        .if_inst  (if_inst3),
        .if_ready (if_ready3),
        .id_valid (id_valid3),
        .id_pc    (id_pc3),
        .id_inst  (id_inst3),
        .id_ready (id_ready3),
        .flush    (flush3)
`ifdef IF_ID_PERF_EN
        ,
        .perf_stall_cnt  (stall_cnt3),
        .perf_bubble_cnt (bubble_cnt3)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; id_ready = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_inst = '0;
        if_valid3 = 1'b0; if_pc3 = '0; if_inst3 = '0;
        id_ready3 = 1'b0; flush3 = 1'b0;
        step();
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b want 0", id_valid);
        end
        checks++;
        if (id_pc !== 32'hBFC0_0000) begin
            errors++; $display("FAIL reset_pc got %h want bfc00000", id_pc);
        end
        checks++;
        if (id_inst !== 32'h0) begin
            errors++; $display("FAIL reset_inst got %h want 0", id_inst);
        end
        checks++;
        if (if_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b want 1", if_ready);
        end
        checks++;
        if (id_valid3 !== 1'b0 || if_ready3 !== 1'b1) begin
            errors++;
            $display("FAIL reset_d3 got v=%b r=%b want v=0 r=1", id_valid3, if_ready3);
        end
`ifdef IF_ID_PERF_EN
        checks++;
        if (stall_cnt !== 32'd0 || bubble_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf got s=%0d b=%0d want 0 0", stall_cnt, bubble_cnt);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        logic [31:0] ins [3];
        pcs = '{32'h1000, 32'h1004, 32'h1008};
        ins = '{32'h2400_1000, 32'h2400_1004, 32'h2400_1008};
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_valid = 1'b1; if_pc = pcs[i]; if_inst = ins[i];
            step();
            checks++;
            if (id_valid !== 1'b1 || id_pc !== pcs[i] || id_inst !== ins[i]
                || if_ready !== 1'b1) begin
                errors++;
                $display("FAIL stream_%0d got v=%b pc=%h inst=%h r=%b want v=1 pc=%h inst=%h r=1",
                         i, id_valid, id_pc, id_inst, if_ready, pcs[i], ins[i]);
            end
        end
        if_valid = 1'b0;
        step();
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'hBFC0_0000 || id_inst !== 32'h0) begin
            errors++;
            $display("FAIL stream_empty got v=%b pc=%h inst=%h want v=0 pc=bfc00000 inst=0",
                     id_valid, id_pc, id_inst);
        end
    endtask

    task automatic test_stall();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h1000; if_inst = 32'h2400_1000;
        step();
        checks++;
        if (if_ready !== 1'b1 || id_pc !== 32'h1000) begin
            errors++;
            $display("FAIL stall_one got r=%b pc=%h want r=1 pc=1000", if_ready, id_pc);
        end
        if_pc = 32'h1004; if_inst = 32'h2400_1004;
        step();
        checks++;
        if (if_ready !== 1'b0 || id_pc !== 32'h1000) begin
            errors++;
            $display("FAIL stall_full got r=%b pc=%h want r=0 pc=1000", if_ready, id_pc);
        end
        if_pc = 32'h1008; if_inst = 32'h2400_1008;
        step();
        checks++;
        if (if_ready !== 1'b0 || id_pc !== 32'h1000 || id_inst !== 32'h2400_1000) begin
            errors++;
            $display("FAIL stall_hold got r=%b pc=%h inst=%h want r=0 pc=1000 inst=24001000",
                     if_ready, id_pc, id_inst);
        end
        id_ready = 1'b1;
        step();
        checks++;
        if (id_pc !== 32'h1004 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_drain0 got pc=%h r=%b want pc=1004 r=1", id_pc, if_ready);
        end
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h1008 || id_inst !== 32'h2400_1008) begin
            errors++;
            $display("FAIL stall_drain1 got v=%b pc=%h inst=%h want v=1 pc=1008 inst=24001008",
                     id_valid, id_pc, id_inst);
        end
        if_valid = 1'b0;
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL stall_empty got v=%b want 0", id_valid);
        end
    endtask

    task automatic test_flush();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hA000; if_inst = 32'h1;
        step();
        if_pc = 32'hA004; if_inst = 32'h2;
        step();
        if_pc = 32'hA008; if_inst = 32'h3;
        id_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_pc !== 32'hBFC0_0000) begin
            errors++;
            $display("FAIL flush_full got v=%b r=%b pc=%h want v=0 r=1 pc=bfc00000",
                     id_valid, if_ready, id_pc);
        end
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_gone got v=%b pc=%h want v=0", id_valid, id_pc);
        end
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hC000; if_inst = 32'h4;
        step();
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'hC000 || id_inst !== 32'h4) begin
            errors++;
            $display("FAIL flush_refill got v=%b pc=%h inst=%h want v=1 pc=c000 inst=4",
                     id_valid, id_pc, id_inst);
        end
        if_pc = 32'hC004; if_inst = 32'h5;
        id_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; if_valid = 1'b0;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_push got v=%b r=%b want v=0 r=1", id_valid, if_ready);
        end
        step();
        checks++;
        if (id_valid !== 1'b0) begin
            errors++; $display("FAIL flush_push_gone got v=%b pc=%h want v=0", id_valid, id_pc);
        end
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'hC008; if_inst = 32'h6;
        step();
        checks++;
        if (id_pc !== 32'hC008 || id_inst !== 32'h6) begin
            errors++;
            $display("FAIL flush_align got pc=%h inst=%h want pc=c008 inst=6", id_pc, id_inst);
        end
        if_pc = 32'hD000; if_inst = 32'h7;
        rst = 1'b1; flush = 1'b1;
        step();
        rst = 1'b0; flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1;
        checks++;
        if (id_valid !== 1'b0 || if_ready !== 1'b1 || id_pc !== 32'hBFC0_0000
            || id_inst !== 32'h0) begin
            errors++;
            $display("FAIL rst_flush got v=%b r=%b pc=%h inst=%h want v=0 r=1 pc=bfc00000 inst=0",
                     id_valid, if_ready, id_pc, id_inst);
        end
    endtask

    task automatic test_wrap_depth3();
        int k = 0;
        int n = 0;
        logic [31:0] exp_pc;
        for (int c = 0; c < 60 && n < 7; c++) begin
            if_valid3 = (k < 7);
            if_pc3    = 32'h2000 + 32'(k * 4);
            if_inst3  = {16'hA5A5, if_pc3[15:0]};
            id_ready3 = !(c < 4 || c == 7 || c == 8 || c == 12);
            if (c == 3) begin
                checks++;
                if (if_ready3 !== 1'b0 || id_pc3 !== 32'h2000) begin
                    errors++;
                    $display("FAIL wrap_full got r=%b pc=%h want r=0 pc=2000",
                             if_ready3, id_pc3);
                end
            end
            if (id_valid3 && id_ready3) begin
                exp_pc = 32'h2000 + 32'(n * 4);
                checks++;
                if (id_pc3 !== exp_pc || id_inst3 !== {16'hA5A5, exp_pc[15:0]}) begin
                    errors++;
                    $display("FAIL wrap_pop%0d got pc=%h inst=%h want pc=%h inst=%h",
                             n, id_pc3, id_inst3, exp_pc, {16'hA5A5, exp_pc[15:0]});
                end
                n++;
            end
            if (if_valid3 && if_ready3) k++;
            step();
        end
        if_valid3 = 1'b0;
        checks++;
        if (n !== 7) begin
            errors++; $display("FAIL wrap_count got %0d pops want 7", n);
        end
    endtask

`ifdef IF_ID_PERF_EN
    task automatic test_perf();
        rst = 1'b1; if_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        if_valid = 1'b1; if_pc = 32'hE000; if_inst = 32'h8;
        step();
        if_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (stall_cnt !== 32'd5) begin
            errors++; $display("FAIL perf_stall got %0d want 5", stall_cnt);
        end
        checks++;
        if (bubble_cnt !== 32'd3) begin
            errors++; $display("FAIL perf_bubble got %0d want 3", bubble_cnt);
        end
        id_ready = 1'b1;
        step();
    endtask
`endif

    initial begin
        test_reset();
`ifdef IF_ID_PERF_EN
        test_perf();
`endif
        test_stream();
        test_stall();
        test_flush();
        test_wrap_depth3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Parametrised IF/ID pipeline stage for the MIPS core: a registered, elastic buffer between fetch and decode carrying `{pc, inst}` pairs. It replaces the fixed single-register PC latch with a `DEPTH`-entry FIFO using valid/ready handshakes on both sides, plus a synchronous flush for branch/exception redirects. Decode sees a registered head entry. Fetch sees a `if_ready` that depends only on occupancy.

## Interface
Parameters:
- `ADDR_W`, default 32: PC width.
- `INST_W`, default 32: instruction width.
- `DEPTH`, default 2: buffer entries. Legal range 1..8. 2 gives full throughput.
- `INIT_PC`, default 32'hBFC0_0000: value of `id_pc` while empty or after reset.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `if_valid`, in, 1: fetch presents an entry.
- `if_pc`, in, `ADDR_W`: fetch PC.
- `if_inst`, in, `INST_W`: fetched instruction.
- `if_ready`, out, 1: stage can accept an entry this cycle.
- `id_valid`, out, 1: head entry is valid.
- `id_pc`, out, `ADDR_W`: head PC.
- `id_inst`, out, `INST_W`: head instruction.
- `id_ready`, in, 1: decode consumes the head this cycle. Low means decode is stalling.
- `flush`, in, 1: discard all buffered entries and the entry offered this cycle.
- `perf_stall_cnt`, out, 32: present only with `IF_ID_PERF_EN`.
- `perf_bubble_cnt`, out, 32: present only with `IF_ID_PERF_EN`.

## Operation
- Handshake terms:
  - push = `if_valid && if_ready`.
  - pop = `id_valid && id_ready`.
  - `count` ranges 0..`DEPTH`, width `$clog2(DEPTH+1)`.
- `if_ready` = `count < DEPTH`.
  - Purely a function of registered state; no combinational path from `id_ready` or `flush`.
  - Full with a pop in the same cycle still blocks the push.
- `id_valid` = `count != 0`.
  - `id_pc`/`id_inst` come from the head slot, so head data is directly registered.
  - When empty, outputs read `INIT_PC` and 0, which is a NOP (sll $0,$0,0).
- Storage:
  - Circular buffer with `rd_ptr` and `wr_ptr`, each wrapping at `DEPTH`.
  - Non-power-of-2 depths wrap explicitly (`ptr == DEPTH-1 -> 0`).
- Per edge, priority order:
  1. `rst` (highest).
  2. `flush`: `count <= 0`, `rd_ptr <= wr_ptr`. The push and pop in that cycle are both ignored.
  3. Otherwise: push writes at `wr_ptr` and pop advances `rd_ptr`. `count` += push − pop.
- Data in an entry is never modified while the entry is held.
  - Stalled head (`id_valid && !id_ready`) keeps `id_pc`/`id_inst` stable until popped or flushed.
- Delay slot: flush always clears the whole stage. The redirect unit must not assert `flush` until the delay-slot instruction has been popped.

## Timing
- Reset (sync): `count=0`, pointers 0, `id_valid=0`, `id_pc=INIT_PC`, `id_inst=0`, `if_ready=1`. Perf counters are 0.
- Latency: a pushed entry appears on `id_*` at the next edge if the buffer was empty. Otherwise it appears after the entries ahead of it are popped.
- Throughput:
  - `DEPTH>=2`: one entry per cycle sustained.
  - `DEPTH=1`: one entry per 2 cycles, because the full buffer blocks the push.
- Flush: `id_valid=0` the cycle after `flush`. The stage accepts again in that same following cycle (`if_ready=1`).
- `rst` asserted mid-stream: all entries are dropped at that edge, same as flush, and outputs return to their reset values.
- `flush` and `rst` together: reset values result.

## Configuration
- `IF_ID_PERF_EN` defined:
  - `perf_stall_cnt` increments on every cycle with `id_valid && !id_ready`.
  - `perf_bubble_cnt` increments on every cycle with `!id_valid`, flush cycles included.
  - Both are 32-bit, wrap modulo 2^32, and are cleared only by `rst`.
- Not defined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- The shared `defines.v`/package holds:
  - `InstAddrBus`/`InstBus` widths, which become the defaults for `ADDR_W`/`INST_W`.
  - `InitialPc` (the `INIT_PC` default).
  - `NopInst` (0).
  - The `RstEnable` polarity constant.
- One sub-module, `if_id_buf`: the parametrised circular storage.
  - Holds pointers, `count` and the data array, and has a flush input.
  - `if_id_stage` wraps it, adds the output muxing to `INIT_PC`/NOP and the optional perf counters.

## Test plan
- Reset: hold `rst` 2 cycles → `id_valid=0`, `id_pc=32'hBFC00000`, `id_inst=0`, `if_ready=1`.
- Streaming, `DEPTH=2`: push PC 0x1000, 0x1004, 0x1008 on consecutive cycles with `id_ready=1` → `id_pc` shows 0x1000, 0x1004, 0x1008 in consecutive cycles starting 1 cycle after the first push, with no bubbles.
- Stall/backpressure: `id_ready=0` with 3 pushes offered → 2 accepted, `if_ready=0`, head stays 0x1000. Release `id_ready` → in-order drain 0x1000, 0x1004, then 0x1008 accepted.
- Flush with push and pop in the same cycle, buffer holding 2 entries → next cycle `id_valid=0`, `count=0`, and the offered entry is not visible later.
- `DEPTH=3` wrap: push 7 entries through with intermittent stalls → output order preserved across pointer wrap 2→0.
- `IF_ID_PERF_EN`: 5 stall cycles plus 3 empty cycles after reset release → `perf_stall_cnt=5`, `perf_bubble_cnt=3`.
